// File: rtl/uart_periph.sv
// UART peripheral for the peripheral memory bus: TX/RX FIFOs, programmable
// baud divisor, sticky error flags and an RX-available interrupt.
module uart_periph #(
  parameter logic [30:0] BASE_ADDR   = 31'h0000_1000,
  parameter int unsigned TX_DEPTH    = 8,
  parameter int unsigned RX_DEPTH    = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd543
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        bus_valid,
  input  logic [30:0] bus_addr,
  input  logic        bus_write,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wstrb,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);

  localparam int unsigned TXAW = $clog2(TX_DEPTH);
  localparam int unsigned RXAW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  // ---------------- bus interface ----------------
  logic        sel;
  logic [1:0]  req_off;
  logic        req_write;
  logic [15:0] req_wdata;
  logic [1:0]  req_wstrb;
  logic        unused_ok;

  assign sel = bus_valid & (bus_addr[30:12] == BASE_ADDR[30:12]) & ~bus_ready;
  assign unused_ok = &{1'b0, bus_addr[11:4], bus_addr[1:0], bus_wdata[31:16], bus_wstrb[3:2]};

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_ready <= 1'b0;
      req_off   <= '0;
      req_write <= 1'b0;
      req_wdata <= '0;
      req_wstrb <= '0;
    end else begin
      bus_ready <= sel;
      if (sel) begin
        req_off   <= bus_addr[3:2];
        req_write <= bus_write;
        req_wdata <= bus_wdata[15:0];
        req_wstrb <= bus_wstrb[1:0];
      end
    end
  end

  logic wr_tx, rd_rx, wr_st, wr_div;
  assign wr_tx  = bus_ready &  req_write & (req_off == 2'd0) & req_wstrb[0];
  assign rd_rx  = bus_ready & ~req_write & (req_off == 2'd1);
  assign wr_st  = bus_ready &  req_write & (req_off == 2'd2) & req_wstrb[0];
  assign wr_div = bus_ready &  req_write & (req_off == 2'd3);

  // ---------------- divisor ----------------
  logic [15:0] div, div_new;
  assign div_new = {req_wstrb[1] ? req_wdata[15:8] : div[15:8],
                    req_wstrb[0] ? req_wdata[7:0]  : div[7:0]};

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)      div <= DEFAULT_DIV;
    else if (wr_div) div <= (div_new < 16'd4) ? 16'd4 : div_new;
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [TX_DEPTH];
  logic [TXAW:0] tx_wp, tx_rp;
  logic          tx_empty, tx_full, tx_pop, tx_push, tx_ovf_set;
  tx_state_t     tx_state;

  assign tx_empty   = (tx_wp == tx_rp);
  assign tx_full    = (tx_wp[TXAW] != tx_rp[TXAW]) && (tx_wp[TXAW-1:0] == tx_rp[TXAW-1:0]);
  assign tx_pop     = (tx_state == TX_IDLE) & ~tx_empty;
  assign tx_push    = wr_tx & (~tx_full | tx_pop);
  assign tx_ovf_set = wr_tx & tx_full & ~tx_pop;

  always_ff @(posedge sys_clk) begin
    if (tx_push) tx_mem[tx_wp[TXAW-1:0]] <= req_wdata[7:0];
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
    end
  end

  // ---------------- TX shifter ----------------
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      uart_tx  <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          uart_tx <= 1'b1;
          if (!tx_empty) begin
            tx_sh    <= tx_mem[tx_rp[TXAW-1:0]];
            uart_tx  <= 1'b0;
            tx_cnt   <= div - 16'd1;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == '0) begin
            uart_tx  <= tx_sh[0];
            tx_sh    <= {1'b0, tx_sh[7:1]};
            tx_bit   <= '0;
            tx_cnt   <= div - 16'd1;
            tx_state <= TX_DATA;
          end else tx_cnt <= tx_cnt - 16'd1;
        end
        TX_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= div - 16'd1;
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              uart_tx <= tx_sh[0];
              tx_sh   <= {1'b0, tx_sh[7:1]};
              tx_bit  <= tx_bit + 3'd1;
            end
          end else tx_cnt <= tx_cnt - 16'd1;
        end
        default: begin
          if (tx_cnt == '0) tx_state <= TX_IDLE;
          else              tx_cnt   <= tx_cnt - 16'd1;
        end
      endcase
    end
  end

  // ---------------- RX receiver ----------------
  logic        rx_meta, rx_sync, rx_prev;
  rx_state_t   rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_done, rx_ferr;

  assign rx_done = (rx_state == RX_STOP) & (rx_cnt == '0) &  rx_sync;
  assign rx_ferr = (rx_state == RX_STOP) & (rx_cnt == '0) & ~rx_sync;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev & ~rx_sync) begin
            rx_cnt   <= {1'b0, div[15:1]} - 16'd1;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (rx_sync) rx_state <= RX_IDLE;
            else begin
              rx_cnt   <= div - 16'd1;
              rx_bit   <= '0;
              rx_state <= RX_DATA;
            end
          end else rx_cnt <= rx_cnt - 16'd1;
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_sh  <= {rx_sync, rx_sh[7:1]};
            rx_cnt <= div - 16'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt - 16'd1;
        end
        RX_STOP: begin
          if (rx_cnt == '0) rx_state <= rx_sync ? RX_IDLE : RX_WAIT;
          else              rx_cnt   <= rx_cnt - 16'd1;
        end
        default: if (rx_sync) rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]    rx_mem [RX_DEPTH];
  logic [RXAW:0] rx_wp, rx_rp, rx_wp_nxt, rx_rp_nxt;
  logic          rx_empty, rx_full, rx_pop, rx_push, rx_ovr_set;

  assign rx_empty   = (rx_wp == rx_rp);
  assign rx_full    = (rx_wp[RXAW] != rx_rp[RXAW]) && (rx_wp[RXAW-1:0] == rx_rp[RXAW-1:0]);
  assign rx_pop     = rd_rx & ~rx_empty;
  assign rx_push    = rx_done & (~rx_full | rx_pop);
  assign rx_ovr_set = rx_done & rx_full & ~rx_pop;
  assign rx_wp_nxt  = rx_wp + {{RXAW{1'b0}}, rx_push};
  assign rx_rp_nxt  = rx_rp + {{RXAW{1'b0}}, rx_pop};

  always_ff @(posedge sys_clk) begin
    if (rx_push) rx_mem[rx_wp[RXAW-1:0]] <= rx_sh;
  end

  // irq tracks the post-update occupancy so it drops right after the last pop
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp <= '0;
      rx_rp <= '0;
      irq   <= 1'b0;
    end else begin
      rx_wp <= rx_wp_nxt;
      rx_rp <= rx_rp_nxt;
      irq   <= (rx_wp_nxt != rx_rp_nxt);
    end
  end

  // ---------------- sticky flags ----------------
  logic tx_ovf, rx_ovr, frame_err;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ovf    <= 1'b0;
      rx_ovr    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      tx_ovf    <= (tx_ovf    & ~(wr_st & req_wdata[3])) | tx_ovf_set;
      rx_ovr    <= (rx_ovr    & ~(wr_st & req_wdata[4])) | rx_ovr_set;
      frame_err <= (frame_err & ~(wr_st & req_wdata[5])) | rx_ferr;
    end
  end

  // ---------------- read mux ----------------
  logic tx_idle;
  assign tx_idle = tx_empty & (tx_state == TX_IDLE);

  always_comb begin
    bus_rdata = '0;
    if (bus_ready && !req_write) begin
      case (req_off)
        2'd1:    if (!rx_empty) bus_rdata = {1'b1, 23'b0, rx_mem[rx_rp[RXAW-1:0]]};
        2'd2:    bus_rdata = {26'b0, frame_err, rx_ovr, tx_ovf, ~rx_empty, tx_idle, tx_full};
        2'd3:    bus_rdata = {16'b0, div};
        default: bus_rdata = '0;
      endcase
    end
  end

endmodule

// File: doc/uart_periph.md
Name: uart_periph

Overview:
- UART peripheral on the CPU subsystem's peripheral memory bus; a sibling slave to the GPIO subsystem.
- Contains a TX FIFO, an RX FIFO, a programmable baud divisor and sticky error flags.
- Responds only to its own 4 KiB window and drives an RX-available interrupt line.

Parameters:
- BASE_ADDR, 31'h0000_1000, byte base of the 4 KiB register window; bits [11:0] ignored.
- TX_DEPTH, 8, TX FIFO entries; power of 2, ≥2.
- RX_DEPTH, 4, RX FIFO entries; power of 2, ≥2.
- DEFAULT_DIV, 16'd543, reset baud divisor in sys_clk cycles per bit (115200 baud at 62.5 MHz).

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- bus_valid  in  1  request valid; held by the master until bus_ready.
- bus_addr  in  31  byte address.
- bus_write  in  1  1 = write, 0 = read.
- bus_wdata  in  32  write data.
- bus_wstrb  in  4  byte write enables.
- bus_rdata  out  32  read data; valid only while bus_ready=1, else 0.
- bus_ready  out  1  single-cycle completion pulse.
- uart_rx  in  1  asynchronous serial input.
- uart_tx  out  1  serial output, idle high.
- irq  out  1  high while the RX FIFO is non-empty.

Behaviour:
- Reset values: uart_tx=1, bus_ready=0, bus_rdata=0, irq=0, divisor=DEFAULT_DIV, both FIFOs empty, sticky flags 0, TX/RX FSMs IDLE.
- Select: sel = bus_valid & (bus_addr[30:12]==BASE_ADDR[30:12]) & ~bus_ready. Unselected accesses are ignored (bus_ready stays 0).
- Bus timing:
  - bus_ready rises exactly 1 cycle after sel and lasts 1 cycle.
  - Write side effects and read pops take effect on the bus_ready cycle.
  - A back-to-back request can start no earlier than the cycle after bus_ready.
- Register map (offset bits [3:2]; bits [11:4] ignored, so the map aliases):
  - 0x0 TXDATA (W): if wstrb[0], push wdata[7:0]. If the TX FIFO is full, drop the byte and set tx_overflow. Reads return 0.
  - 0x4 RXDATA (R): returns {rx_valid, 23'b0, byte} and pops the head if non-empty. If empty, returns 0 with no pop. Writes ignored.
  - 0x8 STATUS (R/W1C):
    - bit0 tx_full, bit1 tx_idle (FIFO empty & shifter IDLE), bit2 rx_avail.
    - bit3 tx_overflow, bit4 rx_overrun, bit5 frame_err.
    - A write with wstrb[0] clears each of bits 3-5 where wdata has a 1.
    - Other bits read 0.
  - 0xC DIVISOR (R/W): 16 bits, byte-lane writes via wstrb[1:0]. A resulting value <4 is stored as 4. Reads return {16'b0, div}.
- Simultaneous events:
  - TX FIFO push and shifter pop in the same cycle: both occur. A full FIFO that pops that cycle accepts the push.
  - Same for RX FIFO pop and received-byte push.
  - A sticky-flag set in the same cycle as its W1C clear leaves the flag set.
- TX FSM:
  - States: IDLE → START → DATA ×8 (LSB first) → STOP → IDLE.
  - Each state lasts exactly div cycles; uart_tx is registered.
  - Leaves IDLE in the cycle after the FIFO is non-empty, popping the head.
  - Divisor changes take effect at the next bit boundary.
- RX path:
  - 2-flop synchroniser on uart_rx.
  - FSM IDLE → START → DATA ×8 → STOP.
  - IDLE detects a synced falling edge, then samples at div/2 (floor). If the line is high there, it is a false start → IDLE.
  - Data and stop samples are taken every div cycles after the start mid-sample.
  - Stop bit = 0: set frame_err, discard the byte, and wait for the line high before returning to IDLE.
  - Good byte with RX FIFO full: set rx_overrun and drop the byte.
- irq = rx_avail, registered; deasserts the cycle after the last byte is popped.
- Reset mid-frame: uart_tx returns to 1 immediately (asynchronously) and all partial state is discarded.

Test Plan:
- Reset, then read DIVISOR and STATUS → 0x0000021F and 0x00000002 (tx_idle=1); uart_tx=1; bus_ready pulses exactly 1 cycle after valid.
- Write DIVISOR=0x10, then TXDATA=0xA5 → uart_tx low for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, stop high, then tx_idle=1.
- Write DIVISOR=2 → reads back 4. Write 9 bytes back-to-back with div=4 → first 8 transmitted (one pops early, so 9th accepted only if the shifter popped); verify tx_overflow matches the FIFO occupancy model. W1C 0x8 clears it.
- Drive 0x3C on uart_rx at div=16 → irq=1 after the stop mid-sample; RXDATA reads 0x8000003C; the next read returns 0; irq drops.
- Glitch uart_rx low for 3 cycles (div=16) → no byte, no flags. Send 0x55 with the stop bit low → frame_err=1, RX FIFO empty.
- Send 5 bytes without reading (RX_DEPTH=4) → rx_overrun=1; reads return the first 4 bytes in order. Assert rst_n=0 mid-TX → uart_tx=1 immediately, status returns to reset values.
